// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch
// Description : Single-outstanding instruction fetch unit between PC register,
//               instruction memory and decode, with one-deep pending PC and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
    parameter int CPU_WIDTH = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPU_WIDTH-1:0] curr_pc,
    input  logic                 pc_update,
    input  logic                 flush,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [CPU_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [CPU_WIDTH-1:0] imem_rsp_data,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [CPU_WIDTH-1:0] instr,
    output logic [CPU_WIDTH-1:0] instr_pc,
    output logic                 fetch_busy,
    output logic                 misalign_err,
    output logic [CNT_WIDTH-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [CPU_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic                 drop_q, drop_d;
    logic [CPU_WIDTH-1:0] addr_q, addr_d;
    logic [CPU_WIDTH-1:0] instr_q, instr_d;
    logic [CPU_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                 misalign_q, misalign_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 w_start_vld;
    logic [CPU_WIDTH-1:0] w_start_pc;
    logic                 w_handoff;

    assign w_start_vld = pc_update | pend_vld_q;
    assign w_start_pc  = pc_update ? curr_pc : pend_pc_q;

    always_comb begin
        state_d    = state_q;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
        drop_d     = drop_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        misalign_d = 1'b0;
        cnt_d      = cnt_q;
        w_handoff  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!flush && w_start_vld) begin
                    if (!pc_update) begin
                        pend_vld_d = 1'b0;
                    end
                    if (w_start_pc[1:0] == 2'b00) begin
                        addr_d     = w_start_pc;
                        instr_pc_d = w_start_pc;
                        state_d    = S_REQ;
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // A flushed request still completes; its response is dropped later.
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        instr_d = imem_rsp_data;
                        state_d = S_HOLD;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (instr_ready) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (pc_update && (curr_pc[1:0] == 2'b00)) begin
                        w_handoff  = 1'b1;
                        pend_vld_d = 1'b0;
                        addr_d     = curr_pc;
                        instr_pc_d = curr_pc;
                        state_d    = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase

        if (flush) begin
            pend_vld_d = 1'b0;
        end
        if (pc_update && (flush || ((state_q != S_IDLE) && !w_handoff))) begin
            pend_pc_d  = curr_pc;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
            drop_q     <= 1'b0;
            addr_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
            drop_q     <= drop_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign instr_valid    = (state_q == S_HOLD);
    assign fetch_busy     = (state_q != S_IDLE) || pend_vld_q;
    assign imem_req_addr  = addr_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign misalign_err   = misalign_q;
    assign fetch_cnt      = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Directed self-checking bench for ifu_fetch (CNT_WIDTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] curr_pc;
    logic        pc_update;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_busy;
    logic        misalign_err;
    logic [3:0]  fetch_cnt;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int n_acc   = 0;
    bit seen200 = 1'b0;

    ifu_fetch #(.CPU_WIDTH(32), .CNT_WIDTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .curr_pc        (curr_pc),
        .pc_update      (pc_update),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_busy     (fetch_busy),
        .misalign_err   (misalign_err),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Independent observation of accepted memory requests.
    always @(posedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) begin
            n_acc++;
            if (imem_req_addr == 32'h200) seen200 = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data);
        curr_pc = pc; pc_update = 1'b1; imem_req_ready = 1'b1;
        tick();
        pc_update = 1'b0;
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = data;
        tick();
        imem_rsp_valid = 1'b0;
        chk("loop_instr", instr, data);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; curr_pc = '0; pc_update = 1'b0; flush = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0;
        tick(); tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
        chk("rst_cnt", 32'(fetch_cnt), 32'd0);
        rst = 1'b0;

        // Basic fetch
        curr_pc = 32'h100; pc_update = 1'b1; imem_req_ready = 1'b1;
        tick();
        pc_update = 1'b0;
        chk("basic_req_valid", 32'(imem_req_valid), 32'd1);
        chk("basic_req_addr", imem_req_addr, 32'h100);
        chk("basic_busy", 32'(fetch_busy), 32'd1);
        tick();
        chk("basic_req_dropped", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00500093;
        tick();
        imem_rsp_valid = 1'b0;
        chk("basic_instr_valid", 32'(instr_valid), 32'd1);
        chk("basic_instr", instr, 32'h00500093);
        chk("basic_instr_pc", instr_pc, 32'h100);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0; imem_req_ready = 1'b0;
        chk("basic_cnt", 32'(fetch_cnt), 32'd1);
        chk("basic_idle_valid", 32'(instr_valid), 32'd0);
        chk("basic_idle_busy", 32'(fetch_busy), 32'd0);

        // Backpressure on both channels
        curr_pc = 32'h104; pc_update = 1'b1;
        tick();
        pc_update = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_req_valid", 32'(imem_req_valid), 32'd1);
            chk("bp_req_addr", imem_req_addr, 32'h104);
            tick();
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("bp_req_done", 32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAAAA0001;
        tick();
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_instr_valid", 32'(instr_valid), 32'd1);
            chk("bp_instr", instr, 32'hAAAA0001);
            chk("bp_instr_pc", instr_pc, 32'h104);
            tick();
        end
        chk("bp_cnt_held", 32'(fetch_cnt), 32'd1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("bp_cnt", 32'(fetch_cnt), 32'd2);
        chk("bp_accepts", 32'(n_acc), 32'd2);

        // Misaligned PC
        curr_pc = 32'h102; pc_update = 1'b1;
        tick();
        pc_update = 1'b0;
        chk("mis_err", 32'(misalign_err), 32'd1);
        chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("mis_err_pulse", 32'(misalign_err), 32'd0);
        chk("mis_req_valid2", 32'(imem_req_valid), 32'd0);
        chk("mis_busy", 32'(fetch_busy), 32'd0);

        // Pending PC with overwrite while in WAIT
        curr_pc = 32'h108; pc_update = 1'b1; imem_req_ready = 1'b1;
        tick();
        pc_update = 1'b0;
        tick();
        imem_req_ready = 1'b0;
        curr_pc = 32'h200; pc_update = 1'b1;
        tick();
        curr_pc = 32'h300;
        tick();
        pc_update = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11110000;
        tick();
        imem_rsp_valid = 1'b0;
        chk("pend_instr_pc", instr_pc, 32'h108);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("pend_busy_idle", 32'(fetch_busy), 32'd1);
        tick();
        chk("pend_req_valid", 32'(imem_req_valid), 32'd1);
        chk("pend_req_addr", imem_req_addr, 32'h300);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h22220000;
        tick();
        imem_rsp_valid = 1'b0;
        chk("pend_instr", instr, 32'h22220000);
        chk("pend_instr_pc2", instr_pc, 32'h300);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("pend_cnt", 32'(fetch_cnt), 32'd4);
        chk("pend_busy_clear", 32'(fetch_busy), 32'd0);
        chk("pend_no_200", 32'(seen200), 32'd0);

        // Flush in WAIT with a new PC in the flush cycle
        curr_pc = 32'h10C; pc_update = 1'b1; imem_req_ready = 1'b1;
        tick();
        pc_update = 1'b0;
        tick();
        imem_req_ready = 1'b0;
        flush = 1'b1; pc_update = 1'b1; curr_pc = 32'h400;
        tick();
        flush = 1'b0; pc_update = 1'b0;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0BAD0;
        tick();
        imem_rsp_valid = 1'b0;
        chk("flush_no_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("flush_no_valid2", 32'(instr_valid), 32'd0);
        chk("flush_req_valid", 32'(imem_req_valid), 32'd1);
        chk("flush_req_addr", imem_req_addr, 32'h400);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h33330000;
        tick();
        imem_rsp_valid = 1'b0;
        chk("flush_instr", instr, 32'h33330000);
        chk("flush_instr_pc", instr_pc, 32'h400);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("flush_cnt", 32'(fetch_cnt), 32'd5);

        // Counter wrap, including one back-to-back handoff
        for (int i = 0; i < 10; i++) begin
            do_fetch(32'h1000 + 32'(i) * 4, 32'hC0DE0000 + 32'(i));
        end
        chk("wrap_cnt15", 32'(fetch_cnt), 32'd15);
        curr_pc = 32'h600; pc_update = 1'b1; imem_req_ready = 1'b1;
        tick();
        pc_update = 1'b0;
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h44;
        tick();
        imem_rsp_valid = 1'b0;
        instr_ready = 1'b1; pc_update = 1'b1; curr_pc = 32'h500;
        tick();
        instr_ready = 1'b0; pc_update = 1'b0;
        chk("b2b_req_valid", 32'(imem_req_valid), 32'd1);
        chk("b2b_req_addr", imem_req_addr, 32'h500);
        chk("b2b_instr_valid", 32'(instr_valid), 32'd0);
        chk("wrap_cnt0", 32'(fetch_cnt), 32'd0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h55;
        tick();
        imem_rsp_valid = 1'b0;
        chk("b2b_instr_pc", instr_pc, 32'h500);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wrap_cnt1", 32'(fetch_cnt), 32'd1);

        // Reset while in REQ
        curr_pc = 32'h700; pc_update = 1'b1;
        tick();
        pc_update = 1'b0;
        chk("rstmid_req_valid", 32'(imem_req_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("rstmid_req_valid0", 32'(imem_req_valid), 32'd0);
        chk("rstmid_addr", imem_req_addr, 32'd0);
        chk("rstmid_instr_valid", 32'(instr_valid), 32'd0);
        chk("rstmid_instr", instr, 32'd0);
        chk("rstmid_instr_pc", instr_pc, 32'd0);
        chk("rstmid_busy", 32'(fetch_busy), 32'd0);
        chk("rstmid_mis", 32'(misalign_err), 32'd0);
        chk("rstmid_cnt", 32'(fetch_cnt), 32'd0);
        rst = 1'b0;
        tick();
        chk("rstmid_idle", 32'(imem_req_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the rvseed core. Sits directly downstream of the PC register: it consumes the registered current PC and its one-cycle update pulse, issues a single read to instruction memory over a valid/ready request channel, and captures the returned word. It then presents the word with its PC to decode under a valid/ready handshake. It reports busy so next-PC logic can hold its enable, and it supports a pipeline flush that discards in-flight fetches.

## Interface
- CPU_WIDTH, 32, address and instruction width
- CNT_WIDTH, 32, width of the delivered-instruction counter

- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- curr_pc  in  CPU_WIDTH  current PC from the PC register
- pc_update  in  1  one-cycle pulse; curr_pc holds a new PC this cycle
- flush  in  1  discard the current fetch and any pending PC
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  CPU_WIDTH  fetch address
- imem_rsp_valid  in  1  read data valid (one-cycle pulse)
- imem_rsp_data  in  CPU_WIDTH  read data
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts the instruction
- instr  out  CPU_WIDTH  fetched instruction
- instr_pc  out  CPU_WIDTH  PC of instr
- fetch_busy  out  1  high whenever state != IDLE or a pending PC exists
- misalign_err  out  1  one-cycle pulse: the accepted PC has curr_pc[1:0] != 0
- fetch_cnt  out  CNT_WIDTH  count of instructions delivered to decode

## Operation
- All outputs are registered or are decoded directly from state registers. Every output is 0 after reset; the state register resets to IDLE, and pend_vld, pend_pc, drop and fetch_cnt reset to 0.
- The unit uses four states: IDLE, REQ, WAIT, HOLD.
- **Start source.** In IDLE, the start PC is curr_pc when pc_update is high; otherwise it is pend_pc when pend_vld is high. pc_update has priority, and pend_vld clears when its PC is consumed.
- **IDLE.**
  - If a start PC exists with bits [1:0] == 0: latch it into imem_req_addr and instr_pc, then go to REQ.
  - If a start PC exists with bits [1:0] != 0: pulse misalign_err for one cycle and stay in IDLE. No request is issued.
- **REQ.** imem_req_valid is high and imem_req_addr is held stable. When imem_req_ready is high, go to WAIT.
- **WAIT.** When imem_rsp_valid is high:
  - If drop == 1: clear drop and go to IDLE.
  - Otherwise: register imem_rsp_data into instr and go to HOLD.
  - A response can arrive no earlier than the cycle after the request is accepted. Any imem_rsp_valid outside WAIT is ignored.
- **HOLD.** instr_valid is high, and instr and instr_pc are held stable. When instr_ready is high:
  - fetch_cnt increments; it wraps modulo 2^CNT_WIDTH.
  - If pc_update is high in the same cycle with an aligned PC, go directly to REQ with the new address. This is a back-to-back fetch with no IDLE bubble.
  - Otherwise go to IDLE.
- **pc_update while busy.** A pc_update in REQ, WAIT, or HOLD that is not consumed by the HOLD handoff is stored in pend_pc and sets pend_vld. The store is one deep; a later update overwrites an earlier one.
- **flush.** A flush has highest priority and acts in the cycle it is asserted.
  - pend_vld clears.
  - IDLE or HOLD: go to IDLE, and instr_valid drops the next cycle.
  - REQ: imem_req_valid stays high until the request is accepted; memory requests are never withdrawn. drop is set, and the FSM continues REQ→WAIT.
  - WAIT: drop is set. If imem_rsp_valid arrives in the same cycle, the response is discarded and the FSM goes to IDLE.
  - A pc_update in the same cycle as flush is captured as the new pend_pc, with pend_vld set.
- **Reset.** A reset mid-operation abandons any outstanding response. The integration must reset imem together with this block.

## Timing
- pc_update at cycle T in IDLE → imem_req_valid=1 at T+1.
- Request accepted at cycle A → earliest imem_rsp_valid at A+1.
- imem_rsp_valid at cycle R → instr_valid=1 at R+1.
- Minimum latency from pc_update to instr_valid is 3 cycles.
- Throughput with back-to-back handoff is one instruction per 3 cycles when memory has zero wait.
- misalign_err is asserted in the cycle after the offending start cycle.
- fetch_busy is asserted from T+1 until the cycle after the FSM returns to IDLE with pend_vld=0.
- fetch_cnt updates one cycle after the instr handshake.

## Test plan
- **Basic fetch.** rst for 2 cycles, then pc_update with curr_pc=0x100, imem_req_ready=1, response 0x00500093 one cycle later.
  - Required: req_addr=0x100 at T+1 and instr_valid at T+3 with instr=0x00500093, instr_pc=0x100.
  - instr_ready=1 → fetch_cnt=1 and the FSM returns to IDLE.
- **Backpressure.** Hold imem_req_ready=0 for 4 cycles, then hold instr_ready=0 for 5 cycles.
  - Required: req_addr, instr, and instr_pc stay stable; exactly one request is accepted; fetch_cnt increments only once.
- **Misaligned PC.** pc_update with 0x102.
  - Required: a single misalign_err pulse, no imem_req_valid, state stays IDLE.
- **Pending and overwrite.** While in WAIT, pc_update 0x200 and then pc_update 0x300.
  - Required: after the current instruction hands off, the next request address is 0x300 and 0x200 is never fetched.
- **Flush in WAIT.** Response arrives 2 cycles after the flush, with pc_update 0x400 in the flush cycle.
  - Required: the response is discarded with no instr_valid. The next request is 0x400, and its response is delivered.
- **Counter wrap and reset mid-fetch.** Set CNT_WIDTH=4 and deliver 17 instructions.
  - Required: fetch_cnt=1.
  - Assert rst while in REQ → all outputs 0 on the next edge and state IDLE.
